gfau: RTL and testbench

Galois-field arithmetic unit for prime fields GF(p), 32-bit operands. It performs modular add, subtract, multiply and divide on operands supplied by the point-arithmetic control FSM of the ECC datapath. Each completed operation is reported back to that FSM with a one-cycle done pulse plus a per-operation done flag.

---
 rtl/gfau_pkg.sv | 19 +
 rtl/gfau_mod_div.sv | 120 ++++++++++++
 rtl/gfau.sv | 158 +++++++++++++++
 tb/tb_gfau.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gfau_pkg.sv
// rtl/gfau_pkg.sv - shared width, opcode encodings and FSM states for the GF(p) unit
package gfau_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MULT = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDSUB,
    S_MULT,
    S_DIV,
    S_DONE
  } state_e;

endpackage

// File: rtl/gfau_mod_div.sv
// rtl/gfau_mod_div.sv - binary-inversion divider a*b^-1 mod p, one reduction step per cycle
module gfau_mod_div
  import gfau_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] u_q, v_q, x1_q, x2_q, p_q, res_q;
  logic [WIDTH-1:0] u_d, v_d, x1_d, x2_d, fin_res_d;
  logic             busy_q, done_q, fin_d;

  // x/2 mod p for odd p: add p first when x is odd so the shift is exact
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] p);
    logic [WIDTH:0] t;
    t = {1'b0, x} + (x[0] ? {1'b0, p} : {(WIDTH+1){1'b0}});
    return t[WIDTH:1];
  endfunction

  // (x - y) mod p, adding p back on borrow
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] p);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    return d[WIDTH] ? d[WIDTH-1:0] + p : d[WIDTH-1:0];
  endfunction

  // One inversion step, then decide whether the stepped values end the run.
  // A zero u or v means gcd(b,p) != 1 (only with illegal operands); stop with 0.
  always_comb begin
    u_d  = u_q;
    v_d  = v_q;
    x1_d = x1_q;
    x2_d = x2_q;
    if (!u_q[0]) begin
      u_d  = u_q >> 1;
      x1_d = half_mod(x1_q, p_q);
    end else if (!v_q[0]) begin
      v_d  = v_q >> 1;
      x2_d = half_mod(x2_q, p_q);
    end else if (u_q >= v_q) begin
      u_d  = u_q - v_q;
      x1_d = sub_mod(x1_q, x2_q, p_q);
    end else begin
      v_d  = v_q - u_q;
      x2_d = sub_mod(x2_q, x1_q, p_q);
    end
    fin_d     = 1'b1;
    fin_res_d = '0;
    if (u_d == 1) begin
      fin_res_d = x1_d;
    end else if (v_d == 1) begin
      fin_res_d = x2_d;
    end else if (u_d == 0 || v_d == 0) begin
      fin_res_d = '0;
    end else begin
      fin_d = 1'b0;
    end
  end

  // Operand capture on start, trivial divisors finish at once, else step until done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      u_q    <= '0;
      v_q    <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      p_q    <= '0;
      res_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        u_q  <= b_i;
        v_q  <= p_i;
        x1_q <= a_i;
        x2_q <= '0;
        p_q  <= p_i;
        if (b_i == 0 || p_i == 0) begin
          res_q  <= '0;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end else if (b_i == 1) begin
          res_q  <= a_i;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end else begin
          busy_q <= 1'b1;
        end
      end else if (busy_q) begin
        u_q  <= u_d;
        v_q  <= v_d;
        x1_q <= x1_d;
        x2_q <= x2_d;
        if (fin_d) begin
          res_q  <= fin_res_d;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;

endmodule

// File: rtl/gfau.sv
// rtl/gfau.sv - GF(p) add/sub/mult/div unit; GFAU_DIV_EN adds the inversion-based divider
module gfau
  import gfau_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] prime,
  input  logic [1:0]       operation_select,
  input  logic             done_from_control,
  output logic [WIDTH-1:0] result,
  output logic             done_to_control,
  output logic             done_add,
  output logic             done_sub,
  output logic             done_mult,
  output logic             done_div
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, p_q, acc_q, result_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [3:0]       done_op_q;

  logic [WIDTH-1:0] addsub_d, mult_acc_d;
  logic [WIDTH:0]   sum, sum_red, diff;
  logic [WIDTH:0]   dbl, dbl_red, acc_add, acc_red;

  // Single-cycle add/sub with one conditional correction; div lands here only when disabled
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    sum_red  = sum - {1'b0, p_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    addsub_d = '0;
    if (op_q == OP_ADD) begin
      addsub_d = (sum >= {1'b0, p_q}) ? sum_red[WIDTH-1:0] : sum[WIDTH-1:0];
    end else if (op_q == OP_SUB) begin
      addsub_d = diff[WIDTH] ? diff[WIDTH-1:0] + p_q : diff[WIDTH-1:0];
    end
  end

  // One MSB-first multiply iteration: acc = 2*acc mod p, then + a mod p if bit set
  always_comb begin
    dbl        = {acc_q, 1'b0};
    dbl_red    = (dbl >= {1'b0, p_q}) ? dbl - {1'b0, p_q} : dbl;
    acc_add    = dbl_red + (b_q[WIDTH-1] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    acc_red    = (acc_add >= {1'b0, p_q}) ? acc_add - {1'b0, p_q} : acc_add;
    mult_acc_d = acc_red[WIDTH-1:0];
  end

`ifdef GFAU_DIV_EN
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_result;

  // The engine captures operands on the same edge the FSM leaves IDLE
  assign div_start = (state_q == S_IDLE) && done_from_control && (operation_select == OP_DIV);

  gfau_mod_div #(.WIDTH(WIDTH)) u_div (
    .clk_i   (i_clk),
    .rst_ni  (i_rst),
    .start_i (div_start),
    .a_i     (in_0),
    .b_i     (in_1),
    .p_i     (prime),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .result_o(div_result)
  );
`endif

  // Control FSM: latch in IDLE, compute in the op state, publish result and pulses from DONE
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      op_q      <= OP_ADD;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      done_op_q <= '0;
    end else begin
      done_q    <= 1'b0;
      done_op_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (done_from_control) begin
            a_q   <= in_0;
            b_q   <= in_1;
            p_q   <= prime;
            op_q  <= operation_select;
            acc_q <= '0;
            cnt_q <= '0;
            if (operation_select == OP_MULT) begin
              state_q <= S_MULT;
`ifdef GFAU_DIV_EN
            end else if (operation_select == OP_DIV) begin
              state_q <= S_DIV;
`endif
            end else begin
              state_q <= S_ADDSUB;
            end
          end
        end
        S_ADDSUB: begin
          acc_q   <= addsub_d;
          state_q <= S_DONE;
        end
        S_MULT: begin
          // WIDTH iterations, then one hand-off cycle once the counter saturates
          if (cnt_q == CW'(WIDTH)) begin
            state_q <= S_DONE;
          end else begin
            acc_q <= mult_acc_d;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DIV: begin
`ifdef GFAU_DIV_EN
          if (div_done) begin
            acc_q   <= div_result;
            state_q <= S_DONE;
          end else if (!div_busy) begin
            // engine idle without a result: never strand the controller
            state_q <= S_IDLE;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        S_DONE: begin
          result_q  <= acc_q;
          done_q    <= 1'b1;
          done_op_q <= 4'b0001 << op_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result          = result_q;
  assign done_to_control = done_q;
  assign done_add        = done_op_q[0];
  assign done_sub        = done_op_q[1];
  assign done_mult       = done_op_q[2];
  assign done_div        = done_op_q[3];

endmodule

// File: tb/tb_gfau.sv
// tb/tb_gfau.sv - self-checking bench for gfau against a modular-arithmetic model
module tb_gfau;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_0, in_1, prime, result;
  logic [1:0]  op_sel;
  logic        start;
  logic        done, d_add, d_sub, d_mult, d_div;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign flags = {d_div, d_mult, d_sub, d_add};

  gfau #(.WIDTH(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .in_0             (in_0),
    .in_1             (in_1),
    .prime            (prime),
    .operation_select (op_sel),
    .done_from_control(start),
    .result           (result),
    .done_to_control  (done),
    .done_add         (d_add),
    .done_sub         (d_sub),
    .done_mult        (d_mult),
    .done_div         (d_div)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, p, exp;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] primes[4];
  logic [31:0] b2b_exp;
  logic [1:0]  b2b_op;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic longint unsigned pow_mod(input longint unsigned base,
                                              input longint unsigned e,
                                              input longint unsigned m);
    longint unsigned r = 1;
    longint unsigned bb = base % m;
    longint unsigned ee = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      ee = ee >> 1;
    end
    return r;
  endfunction

  // Reference: plain modular arithmetic; division through Fermat inversion (p prime)
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] p);
    longint unsigned A = a, B = b, P = p, r;
    case (op)
      2'd0: r = (A + B) % P;
      2'd1: r = (A + P - B) % P;
      2'd2: r = (A * B) % P;
      default: begin
`ifdef GFAU_DIV_EN
        if (B == 0) r = 0;
        else r = (A * pow_mod(B, P - 2, P)) % P;
`else
        r = 0;
`endif
      end
    endcase
    return r[31:0];
  endfunction

  // 0 means a variable latency that must stay within 2..130
  function automatic int exp_latency(input logic [1:0] op);
    if (op == 2'd2) return 34;
`ifdef GFAU_DIV_EN
    if (op == 2'd3) return 0;
`endif
    return 2;
  endfunction

  task automatic gen(output logic [1:0] op, output logic [31:0] a, output logic [31:0] b,
                     output logic [31:0] p);
    op = 2'($urandom_range(0, 3));
    p  = primes[$urandom_range(0, 3)];
    a  = $urandom % p;
    b  = $urandom % p;
  endtask

  // Start one op at the current (posedge+1) point, wait for done, check everything
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] exp);
    int lat = 0;
    int el;
    logic got = 1'b0;
    in_0 = a; in_1 = b; prime = p; op_sel = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_0 = $urandom; in_1 = $urandom; prime = $urandom; op_sel = 2'($urandom);
    while (lat < 200 && !got) begin
      @(posedge clk); #1;
      lat++;
      got = done;
    end
    if (!got) begin
      fails++; tests++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, lat);
      return;
    end
    check({nm, "_result"}, result, exp);
    check({nm, "_flags"}, flags, 4'b0001 << op);
    el = exp_latency(op);
    if (el != 0) begin
      check({nm, "_latency"}, lat, el);
    end else begin
      tests++;
      if (lat < 2 || lat > 130) begin
        fails++;
        $display("FAIL %s_latency: got %0d required 2..130", nm, lat);
      end
    end
    @(posedge clk); #1;
    check({nm, "_done_width"}, {done, flags}, 5'b0);
    check({nm, "_result_hold"}, result, exp);
  endtask

  task automatic b2b_load(input int k);
    logic [31:0] a, b, p;
    b2b_op = 2'(k % 4);
    p = primes[$urandom_range(0, 3)];
    a = $urandom % p;
    b = $urandom % p;
    in_0 = a; in_1 = b; prime = p; op_sel = b2b_op;
    b2b_exp = model(b2b_op, a, b, p);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int idx, pulses, tail, extra;
    logic prev;
    logic [1:0]  rop;
    logic [31:0] ra, rb, rp;

    primes[0] = 32'h0000_0061;
    primes[1] = 32'h0000_FFF1;
    primes[2] = 32'h7FFF_FFFF;
    primes[3] = 32'hFFFF_FFFB;

    vecs[0]  = '{2'd0, 32'h5A, 32'h14, 32'h61, 32'h0D};
    vecs[1]  = '{2'd1, 32'h05, 32'h14, 32'h61, 32'h52};
    vecs[2]  = '{2'd2, 32'h32, 32'h03, 32'h61, 32'h35};
    vecs[3]  = '{2'd3, 32'h01, 32'h02, 32'h61, 32'h31};
    vecs[4]  = '{2'd3, 32'h06, 32'h03, 32'h61, 32'h02};
    vecs[5]  = '{2'd3, 32'h05, 32'h00, 32'h61, 32'h00};
    vecs[6]  = '{2'd0, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'hFFFF_FFF9};
    vecs[7]  = '{2'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'h0000_0001};
    vecs[8]  = '{2'd0, 32'h60, 32'h01, 32'h61, 32'h00};
    vecs[9]  = '{2'd1, 32'h00, 32'h01, 32'h61, 32'h60};
    vecs[10] = '{2'd2, 32'h60, 32'h60, 32'h61, 32'h01};
    vecs[11] = '{2'd3, 32'h2A, 32'h01, 32'h61, 32'h2A};
    vecs[12] = '{2'd3, 32'h01, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'hFFFF_FFFA};
`ifndef GFAU_DIV_EN
    foreach (vecs[i]) if (vecs[i].op == 2'd3) vecs[i].exp = 32'h0;
`endif

    in_0 = '0; in_1 = '0; prime = '0; op_sel = '0; start = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_result", result, 32'h0);
    check("reset_done", {done, flags}, 5'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].exp);
    end

    for (int k = 0; k < 24; k++) begin
      gen(rop, ra, rb, rp);
      run_op($sformatf("rnd%0d_op%0d", k, rop), rop, ra, rb, rp, model(rop, ra, rb, rp));
    end

    // Reset in the middle of a multiply: outputs clear at once and no done follows
    in_0 = 32'h32; in_1 = 32'h03; prime = 32'h61; op_sel = 2'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_result", result, 32'h0);
    check("midreset_done", {done, flags}, 5'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("midreset_no_done", extra, 0);
    run_op("post_reset_add", 2'd0, 32'h5A, 32'h14, 32'h61, 32'h0D);

    // Back-to-back with the start strobe held high: 40 ops, 40 pulses
    idx = 0; pulses = 0; tail = 0; prev = 1'b0;
    b2b_load(0);
    start = 1'b1;
    for (int cyc = 0; cyc < 12000 && tail < 200; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        check("b2b_pulse_width", prev, 1'b0);
        pulses++;
        if (idx < 40) begin
          check($sformatf("b2b%0d_result", idx), result, b2b_exp);
          check($sformatf("b2b%0d_flags", idx), flags, 4'b0001 << b2b_op);
          idx++;
          if (idx < 40) b2b_load(idx);
          else start = 1'b0;
        end
      end
      prev = done;
      if (idx == 40) tail++;
    end
    check("b2b_pulse_count", pulses, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
